// File: rtl/core_pkg.sv
// Shared definitions for the Simplified RISC-V core front end: next-PC source
// encoding and the fixed instruction length in bytes.
package core_pkg;

  typedef enum logic [2:0] {
    PC_SRC_SEQ  = 3'd0,
    PC_SRC_IMM  = 3'd1,
    PC_SRC_ALU  = 3'd2,
    PC_SRC_TRAP = 3'd3,
    PC_SRC_RAS  = 3'd4
  } pc_src_e;

  localparam int ILEN_BYTES = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; push/pop take effect on the next clock edge.
// Disabled cycles (en=0) hold all state; overflow silently drops the oldest entry.
module ras_stack
  import core_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_dat,
  output logic [WIDTH-1:0] top,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    top_idx;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign top_idx = wp_q - PTR_ONE;
  assign empty   = (cnt_q == '0);
  assign top     = empty ? '0 : entries_q[top_idx];

  always_comb begin
    entries_d = entries_q;
    wp_d      = wp_q;
    cnt_d     = cnt_q;
    if (en) begin
      if (push && pop && !empty) begin
        entries_d[top_idx] = push_dat;
      end else if (push) begin
        entries_d[wp_q] = push_dat;
        wp_d            = wp_q + PTR_ONE;
        cnt_d           = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end else if (pop && !empty) begin
        wp_d  = top_idx;
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entries_q <= '{default: '0};
      wp_q      <= '0;
      cnt_q     <= '0;
    end else begin
      entries_q <= entries_d;
      wp_q      <= wp_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: registered PC with 5-way next-PC select, misaligned-target
// trap with epc capture, and a RAS. 1-cycle latency; stall holds PC, epc and RAS.
module pc_unit
  import core_pkg::*;
#(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       RAS_DEPTH    = 4,
  parameter int unsigned       ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [2:0]       pc_src,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [WIDTH-1:0] trap_vec,
  input  logic             ras_push,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             misaligned,
  output logic [WIDTH-1:0] epc
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] target;
  logic             target_bad;

  assign pc_plus4   = pc_q + WIDTH'(ILEN_BYTES);
  assign pc         = pc_q;
  assign epc        = epc_q;
  assign misaligned = mis_q;

  // Reserved encodings fall through to the sequential path.
  always_comb begin
    target = pc_plus4;
    case (pc_src)
      PC_SRC_IMM:  target = pc_q + imm;
      PC_SRC_ALU:  target = alu_res;
      PC_SRC_TRAP: target = trap_vec;
      PC_SRC_RAS:  target = ras_empty ? pc_plus4 : ras_top;
      default:     target = pc_plus4;
    endcase
  end

  // The trap vector is trusted and never alignment-checked.
  assign target_bad = (pc_src != PC_SRC_TRAP) && (|target[ALIGN_BITS-1:0]);

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    mis_d = 1'b0;
    if (!stall) begin
      if (target_bad) begin
        pc_d  = trap_vec;
        epc_d = pc_q;
        mis_d = 1'b1;
      end else begin
        pc_d = target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
    end
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (!stall),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_dat (pc_plus4),
    .top      (ras_top),
    .empty    (ras_empty)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver pushes model expectations each cycle,
// a monitor pops and compares after every rising edge.
module tb_pc_unit;

  localparam logic [31:0] RV    = 32'h0000_1000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  pc_src = 3'd0;
  logic [31:0] imm = '0, alu_res = '0, trap_vec = '0;
  logic        ras_push = 1'b0, ras_pop = 1'b0;
  logic [31:0] pc, pc_plus4, ras_top, epc;
  logic        ras_empty, misaligned;

  pc_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (RV),
    .RAS_DEPTH    (DEPTH),
    .ALIGN_BITS   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .pc_src     (pc_src),
    .imm        (imm),
    .alu_res    (alu_res),
    .trap_vec   (trap_vec),
    .ras_push   (ras_push),
    .ras_pop    (ras_pop),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ras_top    (ras_top),
    .ras_empty  (ras_empty),
    .misaligned (misaligned),
    .epc        (epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] top;
    logic        mis;
    logic        empty;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: architectural state with the RAS as a bounded list of addresses.
  logic [31:0] m_pc = '0, m_epc = '0;
  logic        m_mis = 1'b0;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc",         pc,                 e.pc);
      chk("pc_plus4",   pc_plus4,           e.pc + 32'd4);
      chk("epc",        epc,                e.epc);
      chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
      chk("ras_top",    ras_top,            e.top);
      chk("ras_empty",  {31'd0, ras_empty},  {31'd0, e.empty});
    end
  end

  task automatic step(input logic r, input logic s, input logic [2:0] src,
                      input logic [31:0] im, input logic [31:0] al, input logic [31:0] tv,
                      input logic pu, input logic po);
    logic [31:0] p4, tgt;
    exp_t e;
    @(negedge clk);
    rst_n = r; stall = s; pc_src = src; imm = im; alu_res = al; trap_vec = tv;
    ras_push = pu; ras_pop = po;
    p4 = m_pc + 32'd4;
    if (!r) begin
      m_pc = RV; m_epc = '0; m_mis = 1'b0; m_ras.delete();
    end else if (s) begin
      m_mis = 1'b0;
    end else begin
      case (src)
        3'd1:    tgt = m_pc + im;
        3'd2:    tgt = al;
        3'd3:    tgt = tv;
        3'd4:    tgt = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : p4;
        default: tgt = p4;
      endcase
      if (src != 3'd3 && tgt[1:0] != 2'b00) begin
        m_epc = m_pc; m_pc = tv; m_mis = 1'b1;
      end else begin
        m_pc = tgt; m_mis = 1'b0;
      end
      if (pu && po && m_ras.size() > 0) begin
        m_ras[m_ras.size()-1] = p4;
      end else if (pu) begin
        m_ras.push_back(p4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (po && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
    e.pc = m_pc; e.epc = m_epc; e.mis = m_mis;
    e.empty = (m_ras.size() == 0);
    e.top = e.empty ? 32'd0 : m_ras[m_ras.size()-1];
    exp_q.push_back(e);
  endtask

  // Shorthands: jump to an absolute address, optionally pushing/popping.
  task automatic jmp(input logic [31:0] a, input logic pu, input logic po);
    step(1, 0, 3'd2, 0, a, 32'h80, pu, po);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_imm, r_alu, r_tv;
    // Reset release and sequential fetch.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 3'd0, 0, 0, 0, 0, 0);
    // Backward branch then stall.
    jmp(32'h100, 0, 0);
    step(1, 0, 3'd1, 32'hFFFF_FFF8, 0, 0, 0, 0);
    step(1, 1, 3'd2, 0, 32'h400, 0, 1, 0);
    step(1, 1, 3'd1, 32'h10, 0, 0, 0, 1);
    // Misaligned register-indirect target traps.
    jmp(32'h200, 0, 0);
    step(1, 0, 3'd2, 0, 32'h302, 32'h80, 0, 0);
    step(1, 0, 3'd0, 0, 0, 0, 0, 0);
    step(1, 0, 3'd3, 0, 0, 32'h0000_0102, 0, 0);
    jmp(32'h0, 0, 0);
    // RAS overflow and underflow.
    jmp(32'h10, 1, 0);
    jmp(32'h20, 1, 0);
    jmp(32'h30, 1, 0);
    jmp(32'h40, 1, 0);
    jmp(32'h100, 1, 0);
    repeat (5) step(1, 0, 3'd0, 0, 0, 0, 0, 1);
    step(1, 0, 3'd4, 0, 0, 0, 0, 1);
    // Simultaneous push+pop replaces the top entry.
    jmp(32'h500, 1, 0);
    jmp(32'h600, 1, 1);
    jmp(32'h500, 1, 1);
    step(1, 0, 3'd4, 0, 0, 0, 0, 0);
    step(1, 0, 3'd4, 0, 0, 0, 0, 1);
    // Wrap-around and reset mid-stall with live RAS entries.
    jmp(32'hFFFF_FFFC, 0, 0);
    step(1, 0, 3'd0, 0, 0, 0, 1, 0);
    step(1, 0, 3'd0, 0, 0, 0, 1, 0);
    step(0, 1, 3'd2, 0, 32'h40, 0, 1, 0);
    step(1, 0, 3'd0, 0, 0, 0, 0, 1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r_imm = $urandom;
      if ($urandom_range(0, 3) != 0) r_imm[1:0] = 2'b00;
      r_alu = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 3) != 0) r_alu[1] = 1'b0;
      r_tv = $urandom & 32'hFFFF_FFFC;
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) == 0),
           3'($urandom_range(0, 7)), r_imm, r_alu, r_tv,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end
    step(1, 1, 3'd0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the Simplified RISC-V core. It owns the architectural PC register and selects the next PC from one of five sources: sequential, PC-relative, register-indirect (ALU), trap vector, or a return-address-stack (RAS) prediction.
- It adds stall hold, misaligned-target trapping with exception-PC capture, and a circular RAS of configurable depth.
- It sits between the decode/execute control logic and instruction memory, and supersedes the purely combinational next-PC selection.

Parameters:
- WIDTH, 32, address/data width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (WIDTH bits).
- RAS_DEPTH, 4, number of RAS entries (power of two, >= 2).
- ALIGN_BITS, 2, low target bits that must be zero (2 for IALIGN=32, 1 for compressed support).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hold PC and RAS this cycle.
- pc_src  in  3  0=PC+4, 1=PC+imm, 2=alu_res, 3=trap_vec, 4=RAS top; 5-7 reserved, treated as 0.
- imm  in  WIDTH  sign-extended branch/jump offset.
- alu_res  in  WIDTH  JALR target (bit 0 already cleared by execute).
- trap_vec  in  WIDTH  trap handler address.
- ras_push  in  1  current instruction is a call; push PC+4.
- ras_pop  in  1  current instruction is a return; pop.
- pc  out  WIDTH  current PC (registered).
- pc_plus4  out  WIDTH  PC+4, combinational, for the rd write-back of JAL/JALR.
- ras_top  out  WIDTH  current top-of-stack (0 when empty).
- ras_empty  out  1  RAS holds no valid entries.
- misaligned  out  1  registered 1-cycle pulse: last selected target violated alignment.
- epc  out  WIDTH  PC of the instruction whose target was misaligned.

Behaviour:
- Reset (rst_n=0 at a clock edge): pc=RESET_VECTOR, RAS count=0, RAS pointer=0, all entries=0, misaligned=0, epc=0. Reset wins over every other input. A reset mid-stall or mid-call discards all RAS contents.
- Target computation:
  - All additions are WIDTH-bit, modulo 2^WIDTH; wrap-around is silent (e.g. PC=FFFF_FFFC, src 0 gives 0).
  - pc_src=4 with RAS empty selects PC+4.
- Normal cycle (stall=0):
  - If the selected target has any of bits [ALIGN_BITS-1:0] set and pc_src is not 3: pc<=trap_vec, epc<=pc, misaligned<=1.
  - Otherwise pc<=target and misaligned<=0.
  - trap_vec itself is never alignment-checked.
  - Latency is 1 cycle from inputs to pc.
- Stall cycle (stall=1): pc, epc and RAS hold. misaligned<=0. ras_push and ras_pop are ignored.
- RAS is a circular buffer with write pointer wp and count cnt (0..RAS_DEPTH). The top entry is at wp-1.
  - Push only: entry[wp]<=pc+4; wp<=wp+1; cnt<=min(cnt+1, RAS_DEPTH). On overflow the oldest entry is silently overwritten.
  - Pop only: if cnt>0, wp<=wp-1 and cnt<=cnt-1. A pop when empty is a no-op.
  - Push and pop together (JALR rd=ra, rs1=ra): top entry is replaced with pc+4; wp and cnt are unchanged. If empty, this behaves as a push.
  - The RAS updates even when the instruction's target traps as misaligned. Execute suppresses the push/pop in that case.
- ras_top and ras_empty are combinational from the registered RAS state.

Decomposition:
- Shared package core_pkg holds:
  - enum pc_src_e {PC_SRC_SEQ, PC_SRC_IMM, PC_SRC_ALU, PC_SRC_TRAP, PC_SRC_RAS} of width 3.
  - Constant ILEN_BYTES=4.
- One sub-module, ras_stack (params WIDTH, DEPTH): the circular stack with push/pop/empty/top.
- pc_unit holds the PC register, target mux, alignment check and epc.

Test Plan:
- Reset release with RESET_VECTOR=32'h0000_1000, pc_src=0 for 3 cycles -> pc sequence 1000, 1004, 1008, 100C.
- pc=0x100, pc_src=1, imm=32'hFFFF_FFF8 -> pc=0xF8. Then stall=1 for 2 cycles -> pc stays 0xF8 and misaligned=0.
- pc=0x200, pc_src=2, alu_res=0x302, trap_vec=0x80 -> next pc=0x80, epc=0x200, misaligned=1 for exactly 1 cycle.
- 5 pushes from pc=0x0, 0x10, 0x20, 0x30, 0x40 with RAS_DEPTH=4 -> ras_top=0x44. Then 4 pops -> tops 0x34, 0x24, 0x14, and ras_empty=1. A 5th pop leaves ras_empty=1.
- Simultaneous push+pop at pc=0x500 with top=0x104 -> ras_top=0x504 and count unchanged. pc_src=4 then gives pc=0x504.
- pc=32'hFFFF_FFFC, pc_src=0 -> pc=0. Assert rst_n=0 mid-sequence with 2 RAS entries -> pc=RESET_VECTOR, ras_empty=1.
